// File: rtl/serial_const_mult.sv
// Bit-serial LSB-first multiplier of an unsigned stream by the constant COEFF.
// Optional synchronous word restart input clr is enabled by defining MULTIPLIER_CLR_EN.
module serial_const_mult #(
    parameter int unsigned COEFF   = 7,
    parameter int unsigned COEFF_W = 3
) (
    input  logic clk,
    input  logic reset,
`ifdef MULTIPLIER_CLR_EN
    input  logic clr,
`endif
    input  logic in,
    output logic out
);

    function automatic int unsigned popcount(input int unsigned v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            c = c + {31'b0, v[i]};
        end
        return c;
    endfunction

    localparam int unsigned POP = popcount(COEFF);
    // The carry never exceeds POP-1, so this width always holds it.
    localparam int unsigned CW  = $clog2(POP + 1);
    localparam int unsigned SW  = CW + 1;
    localparam int unsigned HW  = (COEFF_W > 1) ? COEFF_W - 1 : 1;
    localparam logic [COEFF_W-1:0] COEFF_V = COEFF[COEFF_W-1:0];

    logic [HW-1:0] hist_q, hist_d;
    logic [CW-1:0] carry_q, carry_d;
    logic          out_q, out_d;
    logic [HW:0]   window;
    logic [SW-1:0] sum;

    // window[j] is the input bit from j cycles ago; window[0] is the live input.
    assign window = {hist_q, in};

    always_comb begin
        sum = SW'(carry_q);
        for (int j = 0; j < int'(COEFF_W); j++) begin
            if (COEFF_V[j]) begin
                sum = sum + SW'(window[j]);
            end
        end
        out_d   = sum[0];
        carry_d = sum[SW-1:1];
        hist_d  = window[HW-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q  <= '0;
            carry_q <= '0;
            out_q   <= 1'b0;
        end
`ifdef MULTIPLIER_CLR_EN
        else if (clr) begin
            hist_q  <= '0;
            carry_q <= '0;
            out_q   <= 1'b0;
        end
`endif
        else begin
            hist_q  <= hist_d;
            carry_q <= carry_d;
            out_q   <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_serial_const_mult.sv
// Directed bench for serial_const_mult with COEFF=7, COEFF=5 and COEFF=1 instances
// sharing one input stream; each product bit is compared against hand-computed words.
module tb_serial_const_mult;

    logic clk;
    logic reset;
    logic in;
    logic clr;
    logic out7, out5, out1;

    int checks = 0;
    int errors = 0;

    serial_const_mult #(.COEFF(7), .COEFF_W(3)) u7 (
        .clk(clk), .reset(reset),
`ifdef MULTIPLIER_CLR_EN
        .clr(clr),
`endif
        .in(in), .out(out7));

    serial_const_mult #(.COEFF(5), .COEFF_W(3)) u5 (
        .clk(clk), .reset(reset),
`ifdef MULTIPLIER_CLR_EN
        .clr(clr),
`endif
        .in(in), .out(out5));

    serial_const_mult #(.COEFF(1), .COEFF_W(1)) u1 (
        .clk(clk), .reset(reset),
`ifdef MULTIPLIER_CLR_EN
        .clr(clr),
`endif
        .in(in), .out(out1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [31:0] p7;
        logic [31:0] p5;
        logic [31:0] p1;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Optionally pulses reset, releases it, then streams 16 bits of v.x plus zeros.
    task automatic run_word(input vec_t v, input int idx, input bit pulse);
        int e0;
        e0 = errors;
        if (pulse) begin
            @(negedge clk);
            reset = 1'b0;
            in    = 1'b0;
            #1;
            chk($sformatf("w%0d reset out7", idx), out7, 1'b0);
            chk($sformatf("w%0d reset out5", idx), out5, 1'b0);
            chk($sformatf("w%0d reset out1", idx), out1, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        in    = v.x[0];
        for (int t = 0; t < 24; t++) begin
            @(posedge clk);
            #1;
            chk($sformatf("w%0d out7 bit%0d", idx, t), out7, v.p7[t]);
            chk($sformatf("w%0d out5 bit%0d", idx, t), out5, v.p5[t]);
            chk($sformatf("w%0d out1 bit%0d", idx, t), out1, v.p1[t]);
            in = (t + 1 < 16) ? v.x[t + 1] : 1'b0;
        end
        $display("word %0d: x=%0d p7=%0d p5=%0d p1=%0d errors_in_word=%0d",
                 idx, v.x, v.p7, v.p5, v.p1, errors - e0);
    endtask

    initial begin
        vec_t v49;
        reset = 1'b0;
        in    = 1'b0;
        clr   = 1'b0;

        vecs[0] = '{x: 16'd49,    p7: 32'd343,    p5: 32'd245,    p1: 32'd49};
        vecs[1] = '{x: 16'd511,   p7: 32'd3577,   p5: 32'd2555,   p1: 32'd511};
        vecs[2] = '{x: 16'd3,     p7: 32'd21,     p5: 32'd15,     p1: 32'd3};
        vecs[3] = '{x: 16'hA5,    p7: 32'd1155,   p5: 32'd825,    p1: 32'd165};
        vecs[4] = '{x: 16'd0,     p7: 32'd0,      p5: 32'd0,      p1: 32'd0};
        vecs[5] = '{x: 16'd1,     p7: 32'd7,      p5: 32'd5,      p1: 32'd1};
        vecs[6] = '{x: 16'hFFFF,  p7: 32'd458745, p5: 32'd327675, p1: 32'd65535};
        v49 = vecs[0];

        repeat (2) @(posedge clk);

        for (int i = 0; i < 7; i++) begin
            run_word(vecs[i], i, 1'b1);
        end

        // Abort 49 after three bits with an asynchronous reset, then restart cleanly.
        @(negedge clk);
        reset = 1'b1;
        in    = v49.x[0];
        for (int t = 0; t < 3; t++) begin
            @(posedge clk);
            #1;
            in = v49.x[t + 1];
        end
        chk("abort out7 before reset", out7, 1'b1);
        reset = 1'b0;
        #1;
        chk("abort out7 async", out7, 1'b0);
        chk("abort out5 async", out5, 1'b0);
        chk("abort out1 async", out1, 1'b0);
        run_word(v49, 100, 1'b0);

`ifdef MULTIPLIER_CLR_EN
        // Word 3 (two bits), one clr cycle with in=1 ignored, then 49 back-to-back.
        begin
            logic [31:0] p7_seq, p5_seq, p1_seq;
            logic [31:0] in_seq;
            int e0;
            e0     = errors;
            in_seq = {v49.x, 3'b011, 2'b11} >> 2;
            in_seq = (32'(v49.x) << 3) | 32'b111;
            p7_seq = (32'd343 << 3) | 32'b001;
            p5_seq = (32'd245 << 3) | 32'b011;
            p1_seq = (32'd49  << 3) | 32'b011;
            @(negedge clk);
            reset = 1'b0;
            #1;
            @(negedge clk);
            reset = 1'b1;
            in    = in_seq[0];
            clr   = 1'b0;
            for (int t = 0; t < 24; t++) begin
                @(posedge clk);
                #1;
                chk($sformatf("clr out7 bit%0d", t), out7, p7_seq[t]);
                chk($sformatf("clr out5 bit%0d", t), out5, p5_seq[t]);
                chk($sformatf("clr out1 bit%0d", t), out1, p1_seq[t]);
                in  = in_seq[t + 1];
                clr = (t + 1 == 2);
            end
            clr = 1'b0;
            $display("clr restart: words 3 then 49, errors_in_sequence=%0d", errors - e0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
